// File: rtl/unidade_es_if.sv
// Bus between the control unit/datapath and the IN/OUT responder.
// The control side is the master; unidade_es is the slave.
interface unidade_es_if #(
    parameter int LARGURA_CHAVES = 16
);
    logic [4:0]                opcode;
    logic                      escreverOut;
    logic [31:0]               dadoSaida;
    logic [LARGURA_CHAVES-1:0] chaves;
    logic                      confirma;
    logic                      pausa;
    logic [31:0]               dadoEntrada;
    logic [31:0]               displaySaida;
    logic [7:0]                contadorSaidas;

    modport master (
        output opcode, escreverOut, dadoSaida, chaves, confirma,
        input  pausa, dadoEntrada, displaySaida, contadorSaidas
    );

    modport slave (
        input  opcode, escreverOut, dadoSaida, chaves, confirma,
        output pausa, dadoEntrada, displaySaida, contadorSaidas
    );
endinterface

// File: rtl/unidade_es.sv
// IN/OUT responder: stalls the core on IN until a debounced press/release of
// the confirm button, latches switches on the press; OUT latches a display word.
module unidade_es #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LARGURA_CHAVES  = 16
) (
    input  logic        clock,
    input  logic        reset,
    unidade_es_if.slave bus
);
    localparam int         CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [4:0] OP_IN = 5'b00010;

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA_PRESSIONA,
        ESPERA_SOLTA,
        ENTREGA
    } estado_t;

    estado_t       estado;
    logic [1:0]    sincr;
    logic          botao;
    logic [CW-1:0] contador;
    logic          amostra;
    logic          aceita;
    logic          subida;
    logic          descida;
    logic [31:0]   dadoEntradaReg;
    logic [31:0]   displayReg;
    logic [7:0]    contadorReg;
    logic          pausaInt;

    // Edges are decoded on the cycle the debouncer commits, so the FSM reacts
    // on the same clock edge that botao changes.
    assign amostra = sincr[1];
    assign aceita  = (amostra != botao) && (contador == CW'(DEBOUNCE_CYCLES - 1));
    assign subida  = aceita && amostra;
    assign descida = aceita && !amostra;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sincr    <= '0;
            botao    <= 1'b0;
            contador <= '0;
        end else begin
            sincr <= {sincr[0], bus.confirma};
            if (amostra == botao) begin
                contador <= '0;
            end else if (aceita) begin
                botao    <= amostra;
                contador <= '0;
            end else begin
                contador <= contador + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= OCIOSO;
            dadoEntradaReg <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.opcode == OP_IN) estado <= ESPERA_PRESSIONA;
                end
                ESPERA_PRESSIONA: begin
                    if (subida) begin
                        dadoEntradaReg <= 32'(bus.chaves);
                        estado         <= ESPERA_SOLTA;
                    end
                end
                ESPERA_SOLTA: begin
                    if (descida) estado <= ENTREGA;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Stall is combinational so the IN cycle itself already holds the PC.
    assign pausaInt = ((estado == OCIOSO) && (bus.opcode == OP_IN)) ||
                      (estado == ESPERA_PRESSIONA) || (estado == ESPERA_SOLTA);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            displayReg  <= '0;
            contadorReg <= '0;
        end else if (bus.escreverOut && !pausaInt) begin
            displayReg  <= bus.dadoSaida;
            contadorReg <= contadorReg + 8'd1;
        end
    end

    assign bus.pausa          = pausaInt;
    assign bus.dadoEntrada    = dadoEntradaReg;
    assign bus.displaySaida   = displayReg;
    assign bus.contadorSaidas = contadorReg;
endmodule
